// File: rtl/dds_spi_slave.sv
// SPI mode-0 register-access slave for the DDS core: 8-bit instruction plus 32 data bits,
// all SPI pins oversampled by the system clock through 2-flop synchronizers.
module dds_spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        SDIO,
  input  logic        SYNCIO,
  output logic        SDO,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        rd_stb,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] INSTR_LAST = CW'(IW - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(IW + DW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INSTR   = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0] cs_sync_q, sclk_sync_q, sdio_sync_q, syncio_sync_q;
  logic       cs_s, sclk_s, sdio_s, syncio_s;
  logic       sclk_prev_q, cs_prev_q, resync_q, resync_d;
  logic [1:0] settle_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-2:0] instr_q, instr_d;
  logic [DW-2:0] rx_q, rx_d;
  logic [DW-1:0] tx_q, tx_d;
  logic          is_rd_q, is_rd_d;
  logic          load_pend_q, load_pend_d;

  logic          sdo_q, sdo_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_stb_q, rd_stb_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic sclk_rise, sclk_fall, cs_ready, in_frame;
  logic start, shift_en, instr_done, frame_done, frame_abort;

  // Input synchronizers; CS idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q     <= 2'b11;
      sclk_sync_q   <= 2'b00;
      sdio_sync_q   <= 2'b00;
      syncio_sync_q <= 2'b00;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      settle_q      <= 2'd0;
      resync_q      <= 1'b0;
    end else begin
      cs_sync_q     <= {cs_sync_q[0], CS};
      sclk_sync_q   <= {sclk_sync_q[0], SCLK};
      sdio_sync_q   <= {sdio_sync_q[0], SDIO};
      syncio_sync_q <= {syncio_sync_q[0], SYNCIO};
      sclk_prev_q   <= sclk_sync_q[1];
      cs_prev_q     <= cs_sync_q[1];
      settle_q      <= (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      resync_q      <= resync_d;
    end
  end

  assign cs_s     = cs_sync_q[1];
  assign sclk_s   = sclk_sync_q[1];
  assign sdio_s   = sdio_sync_q[1];
  assign syncio_s = syncio_sync_q[1];

  // CS edges only count once the chain holds real pin samples, so a CS held low
  // through reset release is not mistaken for a falling edge.
  assign cs_ready  = (settle_q == 2'd3);
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign in_frame  = (state_q == INSTR) || (state_q == DATA);

  assign start       = (state_q == IDLE) & ~syncio_s & cs_ready & ~cs_s & (cs_prev_q | resync_q);
  assign shift_en    = in_frame & ~syncio_s & ~cs_s & sclk_rise;
  assign instr_done  = shift_en & (state_q == INSTR) & (cnt_q == INSTR_LAST);
  assign frame_done  = (state_q == DATA) & ~syncio_s & sclk_rise & (cnt_q == FRAME_LAST);
  assign frame_abort = in_frame & ~syncio_s & cs_s & ~frame_done;

  // A SYNCIO restart with CS still low re-arms the frame start without a new CS edge.
  always_comb begin
    resync_d = resync_q;
    if (syncio_s)           resync_d = 1'b1;
    else if (start || cs_s) resync_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (syncio_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = INSTR;
        INSTR: begin
          if (frame_abort)     state_d = IDLE;
          else if (instr_done) state_d = DATA;
        end
        DATA: begin
          if (frame_done)       state_d = WAIT_CS;
          else if (frame_abort) state_d = IDLE;
        end
        WAIT_CS: if (cs_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    is_rd_d     = is_rd_q;
    load_pend_d = 1'b0;
    sdo_d       = sdo_q;
    wr_en_d     = 1'b0;
    rd_stb_d    = 1'b0;
    frame_err_d = frame_abort;
    busy_d      = (state_d != IDLE);
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;

    if (start || syncio_s) cnt_d = '0;
    if (shift_en) begin
      cnt_d = cnt_q + CW'(1);
      if (state_q == INSTR) instr_d = {instr_q[IW-3:0], sdio_s};
      else                  rx_d    = {rx_q[DW-3:0], sdio_s};
    end

    if (instr_done) begin
      rd_addr_d   = {instr_q[AW-2:0], sdio_s};
      is_rd_d     = instr_q[IW-2];
      load_pend_d = 1'b1;
    end

    if ((state_q == DATA) && sclk_fall && !syncio_s && is_rd_q) begin
      sdo_d = tx_q[DW-1];
      tx_d  = {tx_q[DW-2:0], 1'b0};
    end
    // rd_addr settled last cycle, so the register file output is valid now.
    if (load_pend_q && (state_q == DATA) && is_rd_q) tx_d = rd_data;
    if (state_d != DATA) sdo_d = 1'b0;

    if (frame_done) begin
      if (is_rd_q) begin
        rd_stb_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = rd_addr_q;
        wr_data_d = {rx_q, sdio_s};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      instr_q     <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      is_rd_q     <= 1'b0;
      load_pend_q <= 1'b0;
      sdo_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      is_rd_q     <= is_rd_d;
      load_pend_q <= load_pend_d;
      sdo_q       <= sdo_d;
      wr_en_q     <= wr_en_d;
      rd_stb_q    <= rd_stb_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign SDO       = sdo_q;
  assign wr_en     = wr_en_q;
  assign rd_stb    = rd_stb_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_dds_spi_slave.sv
// Directed bench for dds_spi_slave: a bit-banged mode-0 SPI master plus strobe monitors.
module tb_dds_spi_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b0;
  logic        SDIO = 1'b0;
  logic        SYNCIO = 1'b0;
  logic        SDO;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data = 32'h0;
  logic        rd_stb;
  logic        frame_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, sdo_cnt = 0, busy_cnt = 0;
  int w0, r0, e0, s0, b0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] miso;

  dds_spi_slave dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .SCLK(SCLK), .SDIO(SDIO), .SYNCIO(SYNCIO),
    .SDO(SDO), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_stb(rd_stb), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe monitors: cycles-high counters, so a stretched pulse also shows up.
  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
    if (rd_stb)    rd_cnt   <= rd_cnt + 1;
    if (frame_err) err_cnt  <= err_cnt + 1;
    if (SDO)       sdo_cnt  <= sdo_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; s0 = sdo_cnt; b0 = busy_cnt;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sdo"},   32'(SDO),       32'h0);
    check({tag, "_wren"},  32'(wr_en),     32'h0);
    check({tag, "_rdstb"}, 32'(rd_stb),    32'h0);
    check({tag, "_ferr"},  32'(frame_err), 32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_wa"},    32'(wr_addr),   32'h0);
    check({tag, "_ra"},    32'(rd_addr),   32'h0);
    check({tag, "_wd"},    wr_data,        32'h0);
  endtask

  // Mode-0 master: data set while SCLK low, SDO captured just before each rising edge.
  task automatic xfer(input logic [7:0] ins, input logic [31:0] dat, input int nbits,
                      input bit raise_cs, output logic [31:0] rx);
    logic [39:0] frame;
    frame = {ins, dat};
    rx = '0;
    CS = 1'b0;
    clks(8);
    for (int i = 0; i < nbits; i++) begin
      SDIO = (i < 40) ? frame[39-i] : 1'b0;
      clks(HALF);
      if (i >= 8 && i < 40) rx = {rx[30:0], SDO};
      SCLK = 1'b1;
      clks(HALF);
      SCLK = 1'b0;
    end
    clks(HALF);
    SDIO = 1'b0;
    if (raise_cs) begin
      CS = 1'b1;
      clks(8);
    end
  endtask

  initial begin
    // Reset values
    clks(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    clks(5);

    // Write frame
    snap();
    xfer(8'h05, 32'hDEADBEEF, 40, 1'b0, miso);
    check("wr_busy_before_cs", 32'(busy), 32'h1);
    check("wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("wr_addr", 32'(last_wa), 32'h5);
    check("wr_data", last_wd, 32'hDEADBEEF);
    check("wr_sdo_quiet", 32'(sdo_cnt - s0), 32'd0);
    CS = 1'b1;
    clks(8);
    check("wr_busy_after_cs", 32'(busy), 32'h0);
    check("wr_held_data", wr_data, 32'hDEADBEEF);

    // Read frame
    rd_data = 32'h12345678;
    snap();
    xfer(8'h83, 32'h0, 40, 1'b1, miso);
    check("rd_addr", 32'(rd_addr), 32'h3);
    check("rd_miso", miso, 32'h12345678);
    check("rd_stb_pulses", 32'(rd_cnt - r0), 32'd1);
    check("rd_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("rd_no_err", 32'(err_cnt - e0), 32'd0);

    // Abort after 20 bits, then a clean write
    snap();
    xfer(8'h07, 32'hFFFFFFFF, 20, 1'b1, miso);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_sdo", 32'(SDO), 32'h0);
    xfer(8'h01, 32'h00000055, 40, 1'b1, miso);
    check("post_abort_wr", 32'(wr_cnt - w0), 32'd1);
    check("post_abort_wa", 32'(last_wa), 32'h1);
    check("post_abort_wd", last_wd, 32'h00000055);

    // SYNCIO restart with CS held low
    snap();
    xfer(8'h1F, 32'hA5A5A5A5, 12, 1'b0, miso);
    SYNCIO = 1'b1;
    clks(6);
    SYNCIO = 1'b0;
    clks(6);
    check("sync_reenter_busy", 32'(busy), 32'h1);
    xfer(8'h1F, 32'hA5A5A5A5, 40, 1'b1, miso);
    check("sync_wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("sync_wa", 32'(last_wa), 32'h1F);
    check("sync_wd", last_wd, 32'hA5A5A5A5);
    check("sync_no_err", 32'(err_cnt - e0), 32'd0);

    // Extra SCLK edges, then back-to-back frame
    snap();
    xfer(8'h0A, 32'h0F0F1234, 45, 1'b1, miso);
    check("extra_wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("extra_wd", last_wd, 32'h0F0F1234);
    check("extra_no_err", 32'(err_cnt - e0), 32'd0);
    xfer(8'h11, 32'hCAFEF00D, 40, 1'b1, miso);
    check("b2b_wr_pulses", 32'(wr_cnt - w0), 32'd2);
    check("b2b_wa", 32'(last_wa), 32'h11);
    check("b2b_wd", last_wd, 32'hCAFEF00D);

    // Reset asserted in DATA
    xfer(8'h02, 32'h13572468, 16, 1'b0, miso);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    clks(4);
    rst_n = 1'b1;
    snap();
    xfer(8'h02, 32'h13572468, 24, 1'b1, miso);
    check("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("midrst_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_no_busy", 32'(busy_cnt - b0), 32'd0);
    xfer(8'h04, 32'h600DF00D, 40, 1'b1, miso);
    check("postrst_wr", 32'(wr_cnt - w0), 32'd1);
    check("postrst_wa", 32'(last_wa), 32'h4);
    check("postrst_wd", last_wd, 32'h600DF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
